// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer around a WIDTH-bit up-counter: counts 0..limit,
// pulses tick at each terminal count, and runs one-shot or periodic.
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; the requester holds valid and data stable until then.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic             tick_nx;
  logic [WIDTH-1:0] lim, lim_nx;
  logic             per, per_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
      lim   <= '0;
      per   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      tick  <= tick_nx;
      lim   <= lim_nx;
      per   <= per_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    tick_nx  = 1'b0;
    lim_nx   = lim;
    per_nx   = per;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          lim_nx   = cmd_limit;
          per_nx   = cmd_periodic;
          count_nx = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        // abort beats both pause and the terminal count
        if (abort) begin
          count_nx = '0;
          state_nx = IDLE;
        end else if (pause) begin
          count_nx = count;
        end else if (count == lim) begin
          count_nx = '0;
          tick_nx  = 1'b1;
          state_nx = per ? RUN : DONE;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      DONE: begin
        count_nx = '0;
        state_nx = IDLE;
      end
      default: begin
        count_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // done is decoded from DONE so it lasts exactly the one cycle spent there
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: one-shot, periodic, pause, abort,
// limit edge cases, busy stall and asynchronous reset.
module tb_counter_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_limit;
  logic       cmd_periodic;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       tick;
  logic       done;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  counter_seq_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_limit    (cmd_limit),
    .cmd_periodic (cmd_periodic),
    .pause        (pause),
    .abort        (abort),
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a command and returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [3:0] lim, input logic per);
    int n;
    n = 0;
    cmd_limit    = lim;
    cmd_periodic = per;
    cmd_valid    = 1'b1;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_count", count, 0);
  endtask

  initial begin
    int ticks;
    int cyc;
    logic [3:0] e;

    rst = 1'b0; cmd_valid = 1'b0; cmd_limit = '0; cmd_periodic = 1'b0;
    pause = 1'b0; abort = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // one-shot, limit 9
    for (int j = 1; j <= 9; j++) exp_q.push_back(j[3:0]);
    send_cmd(4'd9, 1'b0);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      check("os9_count", count, e);
      check("os9_tick_low", tick, 0);
    end
    step(1);
    check("os9_tick", tick, 1);
    check("os9_done", done, 1);
    check("os9_count_wrap", count, 0);
    check("os9_ready_low", cmd_ready, 0);
    step(1);
    check("os9_ready", cmd_ready, 1);
    check("os9_done_clear", done, 0);
    check("os9_tick_clear", tick, 0);

    // periodic, limit 3, then abort
    send_cmd(4'd3, 1'b1);
    ticks = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      check("per3_count", count, c % 4);
      check("per3_tick", tick, (c % 4) == 0);
      if (tick) ticks++;
    end
    check("per3_ticks", ticks, 5);
    check("per3_done_never", done, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("per3_abort_busy", busy, 0);
    check("per3_abort_count", count, 0);
    check("per3_abort_tick", tick, 0);

    // periodic, limit 7, pause 3 cycles at count 2
    send_cmd(4'd7, 1'b1);
    step(2);
    check("pause_at2", count, 2);
    pause = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1);
      check("pause_hold", count, 2);
      check("pause_tick", tick, 0);
    end
    pause = 1'b0;
    cyc = 5;
    while (!tick && cyc < 40) begin
      step(1);
      cyc++;
    end
    check("pause_tick_cycle", cyc, 11);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("pause_abort_idle", busy, 0);

    // abort coinciding with terminal count, one-shot limit 5
    send_cmd(4'd5, 1'b0);
    step(5);
    check("abtc_count", count, 5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abtc_tick", tick, 0);
    check("abtc_done", done, 0);
    check("abtc_busy", busy, 0);
    check("abtc_count0", count, 0);
    step(1);
    check("abtc_done_later", done, 0);

    // limit 0 periodic: tick every cycle
    send_cmd(4'd0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(1);
      check("lim0_tick", tick, 1);
      check("lim0_count", count, 0);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("lim0_abort", busy, 0);

    // limit 15 one-shot: full range
    for (int j = 1; j <= 15; j++) exp_q.push_back(j[3:0]);
    send_cmd(4'd15, 1'b0);
    while (exp_q.size() > 0) begin
      step(1);
      e = exp_q.pop_front();
      check("lim15_count", count, e);
    end
    step(1);
    check("lim15_tick", tick, 1);
    check("lim15_done", done, 1);
    check("lim15_count0", count, 0);
    step(1);
    check("lim15_ready", cmd_ready, 1);

    // command while busy stalls until IDLE
    send_cmd(4'd2, 1'b0);
    cmd_limit = 4'd4; cmd_periodic = 1'b0; cmd_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1);
      check("stall_ready", cmd_ready, 0);
    end
    step(1);
    check("stall_free", cmd_ready, 1);
    step(1);
    cmd_valid = 1'b0;
    check("stall_accept", busy, 1);
    check("stall_count0", count, 0);
    for (int j = 1; j <= 4; j++) begin
      step(1);
      check("stall_run", count, j);
    end
    step(1);
    check("stall_tick", tick, 1);
    check("stall_done", done, 1);
    step(1);

    // asynchronous reset mid-run at count 5
    send_cmd(4'd9, 1'b0);
    step(5);
    check("arst_pre", count, 5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_tick", tick, 0);
    check("arst_done", done, 0);
    step(1);
    rst = 1'b1;
    step(2);
    check("arst_stay_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
